fark_hakemi: RTL and testbench
==============================

Name: fark_hakemi

Overview:
- Round-robin arbiter and sequencer that shares one two-group accumulate-and-difference datapath between two requesters.
- The granted requester streams 2*K operands over a valid/ready handshake: the first K go into accumulator A, the next K into accumulator B.
- After the last operand, the block registers |A-B| and pulses a result strobe tagged with the requester id.
- Sits between operand producers and any consumer of the absolute group difference.

Parameters:
- N, 8, operand width in bits.
- K, 5, operands per group (K>=2). Each packet has 2*K operands.
- Derived (localparam, not overridable): W = N + $clog2(K), the accumulator and result width (11 at defaults).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- istek0  input  1  requester 0 has a packet pending
- veri0  input  N  requester 0 operand
- gecerli0  input  1  veri0 valid
- hazir0  output  1  controller accepts veri0 this cycle
- istek1  input  1  requester 1 has a packet pending
- veri1  input  N  requester 1 operand
- gecerli1  input  1  veri1 valid
- hazir1  output  1  controller accepts veri1 this cycle
- sonuc  output  W  |A-B| of the last completed packet
- sonuc_etkin  output  1  one-cycle strobe: sonuc is new
- sonuc_kaynak  output  1  requester id of the current sonuc
- mesgul  output  1  high whenever state != BOSTA

Behaviour:
- Reset (rst=1 at a clock edge), all synchronous:
  - state=BOSTA; accumulators A and B cleared to 0; operand counter cleared to 0.
  - sonuc=0, sonuc_etkin=0, sonuc_kaynak=0.
  - Last-served register son_kaynak=1, so requester 0 wins the first tie.
  - hazir0=hazir1=0 and mesgul=0 during and after reset.
- Reset mid-packet aborts the packet: partial sums are discarded and no sonuc_etkin is produced.
- State BOSTA:
  - hazir0=hazir1=0.
  - Only one istek high: grant that requester.
  - Both high: grant the requester other than son_kaynak.
  - On grant: aktif<=id, son_kaynak<=id, A<=0, B<=0, counter<=0, next state KABUL.
  - No istek: stay in BOSTA.
- State KABUL:
  - hazir of the aktif requester is 1; the other hazir is 0.
  - hazir is decoded from registered state only; there is no combinational path from any input to hazir.
  - An operand transfers when gecerli && hazir. Counter index i<K adds the operand to A; K<=i<2K adds it to B.
  - Operands are zero-extended to W bits before the add; no overflow is possible.
  - gecerli low means a wait cycle: accumulators and counter hold.
  - After the transfer at i=2K-1, next state is FARK.
  - istek is ignored outside BOSTA. Dropping istek mid-packet neither aborts nor releases the grant.
- State FARK (one cycle), registered at the exit edge:
  - sonuc <= (A>B) ? A-B : B-A; equal sums give 0.
  - sonuc_kaynak<=aktif, sonuc_etkin<=1, next state BOSTA.
- Result outputs:
  - sonuc_etkin is high for exactly one cycle, the first BOSTA cycle after FARK.
  - Arbitration for the next packet proceeds in that same cycle.
  - sonuc and sonuc_kaynak hold until the next FARK exit or reset.
- Latency:
  - Take cycle c as a BOSTA cycle in which istek is sampled high.
  - hazir goes high in cycle c+1.
  - With gecerli held high, the last operand transfers in cycle c+2K, FARK is cycle c+2K+1, and sonuc_etkin is high in cycle c+2K+2 (12 cycles after c at K=5).
  - Each wait cycle adds 1.
- Throughput: back-to-back packets from the two requesters take 2K+2 cycles each. There are no idle gaps beyond the grant cycle.

Test Plan:
- Reset, then istek0=1 with gecerli0 held high; A operands 10,20,30,40,50, B operands 1,2,3,4,5 -> sonuc=135, sonuc_kaynak=0, sonuc_etkin high for exactly 1 cycle, 12 cycles after the istek0 sample; hazir1 stays 0 throughout.
- istek1 only; A operands five of 1, B operands five of 255 -> sonuc=1270 (B>A path, full 11-bit range), sonuc_kaynak=1.
- istek0 and istek1 held high from reset -> grant order 0,1,0,1; each result carries the matching sonuc_kaynak; packets are back-to-back with period 12 cycles.
- Requester 0 toggles gecerli0 every other cycle; all 10 operands are 7 -> equal sums give sonuc=0; latency is 12+9 cycles; no operand is lost or double-counted.
- rst asserted after 3 operand transfers -> next cycle hazir0=0, mesgul=0, no sonuc_etkin, sonuc=0; a following full packet computes correctly from cleared accumulators.
- istek0 drops after 4 transfers while gecerli0 continues -> packet completes normally and the result is correct.

Source files
------------

// File: rtl/fark_hakemi.sv
// -----------------------------------------------------------------------------
// fark_hakemi
//
// Round-robin arbiter and sequencer that shares one two-group
// accumulate-and-difference datapath between two requesters.
//
// The granted requester streams 2*K operands over a valid/ready handshake.
// The first K operands are summed into accumulator A and the next K into
// accumulator B. One cycle after the last operand the block registers |A-B|
// and raises a one-cycle result strobe tagged with the requester id.
//
// Parameters
//   N  operand width in bits
//   K  operands per group (K >= 2); a packet is 2*K operands
//   W  (derived) accumulator / result width = N + clog2(K)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   istek0/1      requester has a packet pending (only looked at while idle)
//   veri0/1       requester operand
//   gecerli0/1    operand valid
//   hazir0/1      controller accepts the operand this cycle (registered decode)
//   sonuc         |A-B| of the last completed packet
//   sonuc_etkin   one-cycle strobe: sonuc is new
//   sonuc_kaynak  requester id of the current sonuc
//   mesgul        high whenever the controller is not idle
// -----------------------------------------------------------------------------
module fark_hakemi #(
  parameter int N = 8,
  parameter int K = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    istek0,
  input  logic [N-1:0]            veri0,
  input  logic                    gecerli0,
  output logic                    hazir0,
  input  logic                    istek1,
  input  logic [N-1:0]            veri1,
  input  logic                    gecerli1,
  output logic                    hazir1,
  output logic [N+$clog2(K)-1:0]  sonuc,
  output logic                    sonuc_etkin,
  output logic                    sonuc_kaynak,
  output logic                    mesgul
);

  // Accumulator width: K operands of at most 2^N-1 each always fit.
  localparam int W  = N + $clog2(K);
  // Operand counter spans one whole packet (0 .. 2K-1).
  localparam int CW = $clog2(2 * K);

  localparam logic [CW-1:0] IDX_B_START = CW'(K);
  localparam logic [CW-1:0] IDX_LAST    = CW'(2 * K - 1);

  typedef enum logic [1:0] {
    BOSTA = 2'd0,   // idle / arbitrating
    KABUL = 2'd1,   // accepting operands from the granted requester
    FARK  = 2'd2    // one-cycle difference stage
  } state_t;

  state_t state_reg, state_next;

  logic          aktif_reg;        // requester currently being served
  logic          son_kaynak_reg;   // last requester granted (round-robin pointer)
  logic [W-1:0]  acc_a_reg;
  logic [W-1:0]  acc_b_reg;
  logic [CW-1:0] sayac_reg;        // index of the next operand within the packet
  logic [W-1:0]  sonuc_reg;
  logic          sonuc_etkin_reg;
  logic          sonuc_kaynak_reg;

  // ---------------------------------------------------------------------------
  // Request side: arbitration and operand selection
  // ---------------------------------------------------------------------------
  logic          istek_any;
  logic          grant_id;
  logic [N-1:0]  veri_sec;
  logic          gecerli_sec;
  logic [W-1:0]  veri_ext;
  logic          transfer;
  logic          grup_b;
  logic          son_operand;
  logic [W-1:0]  fark_abs;

  assign istek_any = istek0 | istek1;

  // Single requester wins outright; on a tie the one not served last wins.
  // With only istek1 high this picks 1, with only istek0 high it picks 0.
  assign grant_id = (istek0 & istek1) ? ~son_kaynak_reg : istek1;

  assign veri_sec    = aktif_reg ? veri1 : veri0;
  assign gecerli_sec = aktif_reg ? gecerli1 : gecerli0;
  assign veri_ext    = {{(W-N){1'b0}}, veri_sec};

  // In KABUL the active requester's hazir is always 1, so valid alone
  // completes the handshake.
  assign transfer    = (state_reg == KABUL) && gecerli_sec;
  assign grup_b      = (sayac_reg >= IDX_B_START);
  assign son_operand = (sayac_reg == IDX_LAST);

  assign fark_abs = (acc_a_reg > acc_b_reg) ? (acc_a_reg - acc_b_reg)
                                            : (acc_b_reg - acc_a_reg);

  // One-hot view of the active requester, used for the hazir decode.
  logic [1:0] aktif_oh;
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_aktif_oh
      assign aktif_oh[gi] = (aktif_reg == 1'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BOSTA;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOSTA: begin
        if (istek_any) begin
          state_next = KABUL;
        end
      end
      KABUL: begin
        if (transfer && son_operand) begin
          state_next = FARK;
        end
      end
      FARK: begin
        state_next = BOSTA;
      end
      default: begin
        state_next = BOSTA;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  logic [1:0] hazir_vec;

  always_comb begin
    hazir_vec = 2'b00;
    mesgul    = 1'b0;
    if (state_reg == KABUL) begin
      hazir_vec = aktif_oh;
    end
    if (state_reg != BOSTA) begin
      mesgul = 1'b1;
    end
  end

  assign hazir0 = hazir_vec[0];
  assign hazir1 = hazir_vec[1];

  // ---------------------------------------------------------------------------
  // Datapath and arbitration registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      aktif_reg        <= 1'b0;
      son_kaynak_reg   <= 1'b1;   // requester 0 wins the first tie
      acc_a_reg        <= '0;
      acc_b_reg        <= '0;
      sayac_reg        <= '0;
      sonuc_reg        <= '0;
      sonuc_etkin_reg  <= 1'b0;
      sonuc_kaynak_reg <= 1'b0;
    end else begin
      // Strobe defaults low; only the FARK exit raises it for one cycle.
      sonuc_etkin_reg <= 1'b0;
      case (state_reg)
        BOSTA: begin
          if (istek_any) begin
            aktif_reg      <= grant_id;
            son_kaynak_reg <= grant_id;
            acc_a_reg      <= '0;
            acc_b_reg      <= '0;
            sayac_reg      <= '0;
          end
        end
        KABUL: begin
          if (transfer) begin
            if (grup_b) begin
              acc_b_reg <= acc_b_reg + veri_ext;
            end else begin
              acc_a_reg <= acc_a_reg + veri_ext;
            end
            sayac_reg <= sayac_reg + CW'(1);
          end
        end
        FARK: begin
          sonuc_reg        <= fark_abs;
          sonuc_kaynak_reg <= aktif_reg;
          sonuc_etkin_reg  <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign sonuc        = sonuc_reg;
  assign sonuc_etkin  = sonuc_etkin_reg;
  assign sonuc_kaynak = sonuc_kaynak_reg;

endmodule

// File: tb/tb_fark_hakemi.sv
// -----------------------------------------------------------------------------
// tb_fark_hakemi
//
// Drives fark_hakemi with directed packets and randomized traffic. A
// packet-level reference model (operand lists, grant pointer, sums) predicts
// every output each cycle; scenario checks add constants from the test plan.
// -----------------------------------------------------------------------------
module tb_fark_hakemi;

  localparam int N = 8;
  localparam int K = 5;
  localparam int W = N + $clog2(K);

  logic          clk = 1'b0;
  logic          rst;
  logic          istek0, istek1;
  logic [N-1:0]  veri0, veri1;
  logic          gecerli0, gecerli1;
  logic          hazir0, hazir1;
  logic [W-1:0]  sonuc;
  logic          sonuc_etkin;
  logic          sonuc_kaynak;
  logic          mesgul;

  always #5 clk = ~clk;

  fark_hakemi #(.N(N), .K(K)) dut (
    .clk          (clk),
    .rst          (rst),
    .istek0       (istek0),
    .veri0        (veri0),
    .gecerli0     (gecerli0),
    .hazir0       (hazir0),
    .istek1       (istek1),
    .veri1        (veri1),
    .gecerli1     (gecerli1),
    .hazir1       (hazir1),
    .sonuc        (sonuc),
    .sonuc_etkin  (sonuc_etkin),
    .sonuc_kaynak (sonuc_kaynak),
    .mesgul       (mesgul)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Operand supply per requester
  int  ops0[$];
  int  ops1[$];
  bit  auto_fill = 1'b0;

  // Observed result strobes
  int  strobe_cyc[$];
  int  strobe_src[$];
  int  strobe_val[$];

  // Reference model: who holds the datapath, what it has accepted so far
  bit  m_busy, m_owner, m_last, m_done;
  int  m_got[$];
  bit  m_strobe;
  int  m_sonuc, m_kaynak;

  function automatic int grup_fark(input int a[2*K]);
    int sa, sb;
    sa = 0;
    sb = 0;
    for (int i = 0; i < K; i++) sa += a[i];
    for (int i = K; i < 2*K; i++) sb += a[i];
    return (sa > sb) ? sa - sb : sb - sa;
  endfunction

  // One clock cycle: present operands, check outputs, advance the model
  // across the coming edge, then move to #1 after that edge.
  task automatic step();
    bit strobe_n;
    int sa, sb;
    if (auto_fill) begin
      while (ops0.size() < 2*K) ops0.push_back($urandom_range(0, 255));
      while (ops1.size() < 2*K) ops1.push_back($urandom_range(0, 255));
    end
    veri0 = (ops0.size() > 0) ? N'(ops0[0]) : N'($urandom);
    veri1 = (ops1.size() > 0) ? N'(ops1[0]) : N'($urandom);

    check_val("hazir0", int'(hazir0), int'(m_busy && !m_done && m_owner == 1'b0));
    check_val("hazir1", int'(hazir1), int'(m_busy && !m_done && m_owner == 1'b1));
    check_val("mesgul", int'(mesgul), int'(m_busy));
    check_val("sonuc_etkin", int'(sonuc_etkin), int'(m_strobe));
    check_val("sonuc", int'(sonuc), m_sonuc);
    check_val("sonuc_kaynak", int'(sonuc_kaynak), m_kaynak);

    if (sonuc_etkin) begin
      strobe_cyc.push_back(cyc);
      strobe_src.push_back(int'(sonuc_kaynak));
      strobe_val.push_back(int'(sonuc));
      $display("[TB] result cycle=%0d src=%0d sonuc=%0d", cyc, sonuc_kaynak, sonuc);
    end

    strobe_n = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_last = 1'b1; m_owner = 1'b0;
      m_got.delete();
      m_sonuc = 0; m_kaynak = 0;
    end else if (m_busy && m_done) begin
      sa = 0;
      sb = 0;
      for (int i = 0; i < K; i++) sa += m_got[i];
      for (int i = K; i < 2*K; i++) sb += m_got[i];
      m_sonuc  = (sa > sb) ? sa - sb : sb - sa;
      m_kaynak = int'(m_owner);
      strobe_n = 1'b1;
      m_busy   = 1'b0;
      m_done   = 1'b0;
    end else if (m_busy) begin
      if (m_owner == 1'b0 && gecerli0) begin
        m_got.push_back(int'(veri0));
        if (ops0.size() > 0) void'(ops0.pop_front());
      end else if (m_owner == 1'b1 && gecerli1) begin
        m_got.push_back(int'(veri1));
        if (ops1.size() > 0) void'(ops1.pop_front());
      end
      if (m_got.size() == 2*K) m_done = 1'b1;
    end else if (istek0 || istek1) begin
      m_owner = (istek0 && istek1) ? !m_last : istek1;
      m_last  = m_owner;
      m_busy  = 1'b1;
      m_got.delete();
    end
    m_strobe = strobe_n;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    istek0 = 1'b0; istek1 = 1'b0; gecerli0 = 1'b0; gecerli1 = 1'b0;
    auto_fill = 1'b0;
    ops0.delete();
    ops1.delete();
    step();
    step();
    rst = 1'b0;
    strobe_cyc.delete();
    strobe_src.delete();
    strobe_val.delete();
  endtask

  task automatic run_strobes(input int n, input int budget);
    for (int i = 0; i < budget && strobe_cyc.size() < n; i++) step();
    check_val("wait_strobe", strobe_cyc.size(), n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int arr[2*K];

    rst = 1'b1;
    istek0 = 1'b0; istek1 = 1'b0; gecerli0 = 1'b0; gecerli1 = 1'b0;
    veri0 = '0; veri1 = '0;
    m_busy = 1'b0; m_done = 1'b0; m_last = 1'b1; m_owner = 1'b0;
    m_strobe = 1'b0; m_sonuc = 0; m_kaynak = 0;
    @(posedge clk);
    #1;

    // Reset state
    check_val("rst_hazir0", int'(hazir0), 0);
    check_val("rst_mesgul", int'(mesgul), 0);
    check_val("rst_sonuc", int'(sonuc), 0);

    // 1: requester 0 alone, A larger
    do_reset();
    ops0 = '{10, 20, 30, 40, 50, 1, 2, 3, 4, 5};
    istek0 = 1'b1; gecerli0 = 1'b1;
    c = cyc;
    step();
    istek0 = 1'b0;
    run_strobes(1, 40);
    if (strobe_cyc.size() >= 1) begin
      check_val("s1_val", strobe_val[0], 135);
      check_val("s1_src", strobe_src[0], 0);
      check_val("s1_lat", strobe_cyc[0] - c, 12);
    end

    // 2: requester 1 alone, B larger, full result range
    do_reset();
    ops1 = '{1, 1, 1, 1, 1, 255, 255, 255, 255, 255};
    istek1 = 1'b1; gecerli1 = 1'b1;
    c = cyc;
    step();
    istek1 = 1'b0;
    run_strobes(1, 40);
    if (strobe_cyc.size() >= 1) begin
      check_val("s2_val", strobe_val[0], 1270);
      check_val("s2_src", strobe_src[0], 1);
      check_val("s2_lat", strobe_cyc[0] - c, 12);
    end

    // 3: both requesting continuously -> alternate grants, back-to-back
    do_reset();
    auto_fill = 1'b1;
    istek0 = 1'b1; istek1 = 1'b1; gecerli0 = 1'b1; gecerli1 = 1'b1;
    c = cyc;
    run_strobes(4, 80);
    if (strobe_cyc.size() >= 4) begin
      check_val("s3_first_lat", strobe_cyc[0] - c, 12);
      for (int i = 0; i < 4; i++) check_val("s3_src", strobe_src[i], i % 2);
      for (int i = 1; i < 4; i++) check_val("s3_period", strobe_cyc[i] - strobe_cyc[i-1], 12);
    end

    // 4: valid toggling, equal sums
    do_reset();
    for (int i = 0; i < 2*K; i++) ops0.push_back(7);
    istek0 = 1'b1; gecerli0 = 1'b0;
    c = cyc;
    step();
    istek0 = 1'b0;
    for (int i = 0; i < 60 && strobe_cyc.size() < 1; i++) begin
      gecerli0 = ((cyc - c) % 2) == 1;
      step();
    end
    check_val("wait_strobe", strobe_cyc.size(), 1);
    if (strobe_cyc.size() >= 1) begin
      check_val("s4_val", strobe_val[0], 0);
      check_val("s4_lat", strobe_cyc[0] - c, 21);
    end
    check_val("s4_ops_left", ops0.size(), 0);
    gecerli0 = 1'b0;

    // 5: reset after three transfers aborts the packet
    do_reset();
    for (int i = 0; i < 2*K; i++) ops0.push_back($urandom_range(0, 255));
    istek0 = 1'b1; gecerli0 = 1'b1;
    step();
    istek0 = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("s5_hazir0", int'(hazir0), 0);
    check_val("s5_mesgul", int'(mesgul), 0);
    check_val("s5_etkin", int'(sonuc_etkin), 0);
    check_val("s5_sonuc", int'(sonuc), 0);
    gecerli0 = 1'b0;
    ops0.delete();
    repeat (15) step();
    check_val("s5_no_strobe", strobe_cyc.size(), 0);
    for (int i = 0; i < 2*K; i++) arr[i] = $urandom_range(0, 255);
    foreach (arr[i]) ops0.push_back(arr[i]);
    istek0 = 1'b1; gecerli0 = 1'b1;
    step();
    istek0 = 1'b0;
    run_strobes(1, 40);
    if (strobe_cyc.size() >= 1) check_val("s5_val", strobe_val[0], grup_fark(arr));

    // 6: istek0 drops mid-packet; packet still completes
    do_reset();
    for (int i = 0; i < 2*K; i++) arr[i] = $urandom_range(0, 255);
    foreach (arr[i]) ops0.push_back(arr[i]);
    istek0 = 1'b1; gecerli0 = 1'b1;
    step();
    repeat (4) step();
    istek0 = 1'b0;
    run_strobes(1, 40);
    if (strobe_cyc.size() >= 1) begin
      check_val("s6_val", strobe_val[0], grup_fark(arr));
      check_val("s6_src", strobe_src[0], 0);
    end

    // 7: random requests, valids and operands against the model
    do_reset();
    auto_fill = 1'b1;
    for (int i = 0; i < 800; i++) begin
      istek0   = ($urandom_range(0, 2) != 0);
      istek1   = ($urandom_range(0, 2) != 0);
      gecerli0 = ($urandom_range(0, 3) != 0);
      gecerli1 = ($urandom_range(0, 3) != 0);
      step();
    end
    check_val("s7_activity", int'(strobe_cyc.size() > 0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
